// File: rtl/armleo_stream_pkg.sv
// ---------------------------------------------------------------------------
// armleo_stream_pkg
// Shared definitions for the stream arbiter slice.
//   arb_state_t : arbiter FSM state. IDLE sits between packets and picks the
//                 next port; LOCKED forwards one packet from the granted port.
//   SKID_DEPTH  : number of entries in the optional output skid buffer.
// ---------------------------------------------------------------------------
package armleo_stream_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/armleo_stream_skid.sv
// ---------------------------------------------------------------------------
// armleo_stream_skid
// Two-entry valid/ready skid buffer. Adds one cycle of latency, sustains one
// beat per cycle, and registers the upstream ready so there is no
// combinational path from i_m_ready to o_s_ready.
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   i_s_valid     : upstream beat valid
//   o_s_ready     : upstream beat accept (registered)
//   i_s_data      : upstream payload
//   o_m_valid     : downstream beat valid (registered)
//   i_m_ready     : downstream accept
//   o_m_data      : downstream payload (registered)
// ---------------------------------------------------------------------------
module armleo_stream_skid
   import armleo_stream_pkg::*;
#(
   parameter int PAYLOAD_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_s_valid,
   output logic                 o_s_ready,
   input  logic [PAYLOAD_W-1:0] i_s_data,
   output logic                 o_m_valid,
   input  logic                 i_m_ready,
   output logic [PAYLOAD_W-1:0] o_m_data
);

   // Entry 0 drives the output; entry 1 catches the beat that was accepted
   // upstream in the same cycle the output stalled.
   logic [PAYLOAD_W-1:0]  r_buf [SKID_DEPTH];
   logic [SKID_DEPTH-1:0] r_buf_valid;
   logic                  w_out_free;
   logic                  w_s_xfer;

   assign o_s_ready  = ~r_buf_valid[1];
   assign o_m_valid  = r_buf_valid[0];
   assign o_m_data   = r_buf[0];
   assign w_out_free = ~r_buf_valid[0] | i_m_ready;
   assign w_s_xfer   = i_s_valid & o_s_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_buf_valid <= '0;
      end else if (w_out_free) begin
         // Upstream is held off while entry 1 is full, so draining it into
         // entry 0 never collides with a new incoming beat.
         if (r_buf_valid[1]) begin
            r_buf_valid[0] <= 1'b1;
            r_buf_valid[1] <= 1'b0;
         end else begin
            r_buf_valid[0] <= i_s_valid;
         end
      end else if (w_s_xfer) begin
         r_buf_valid[1] <= 1'b1;
      end
   end

   // NOTE: payload storage has no reset; the valid bits alone decide whether
   // an entry holds a real beat, so clearing the data would buy nothing.
   always_ff @(posedge clk) begin
      if (w_out_free) begin
         if (r_buf_valid[1]) begin
            r_buf[0] <= r_buf[1];
         end else begin
            r_buf[0] <= i_s_data;
         end
      end else if (w_s_xfer) begin
         r_buf[1] <= i_s_data;
      end
   end

endmodule

// File: rtl/armleo_stream_arbiter.sv
// ---------------------------------------------------------------------------
// armleo_stream_arbiter
// Packet-level round-robin merge of WIDTH valid/ready streams into one.
// A port is granted in IDLE (one bubble cycle), then holds the output until
// the beat flagged last is transferred; the priority pointer then moves to
// the port after the one just served.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   in_valid   : per-port beat valid          in_ready : per-port accept
//   in_data    : flat payload, port i at [i*DATA_W +: DATA_W]
//   in_last    : per-port last-beat flag
//   out_valid  : merged beat valid            out_ready : downstream accept
//   out_data   : merged payload               out_last  : merged last flag
//   out_idx    : source port of the current beat
// Configuration:
//   ARMLEO_STREAM_ARBITER_OUTREG_EN : when defined, outputs pass through a
//   two-entry skid buffer (one cycle of latency, registered in_ready).
//   When undefined, outputs are combinational from the granted port.
// ---------------------------------------------------------------------------
module armleo_stream_arbiter
   import armleo_stream_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int DATA_W = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [WIDTH-1:0]         in_valid,
   output logic [WIDTH-1:0]         in_ready,
   input  logic [WIDTH*DATA_W-1:0]  in_data,
   input  logic [WIDTH-1:0]         in_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_last,
   output logic [$clog2(WIDTH)-1:0] out_idx
);

   localparam int IDX_W = $clog2(WIDTH);

   arb_state_t        r_state, w_state_nxt;
   logic [IDX_W-1:0]  r_gidx, w_gidx_nxt;
   logic [IDX_W-1:0]  r_ptr, w_ptr_nxt;
   logic [IDX_W-1:0]  w_scan;
   logic [IDX_W-1:0]  w_pick_idx;
   logic [IDX_W-1:0]  w_gidx_inc;
   logic              w_any_valid;
   logic              w_core_valid;
   logic              w_core_ready;
   logic              w_core_last;
   logic              w_core_xfer;
   logic [DATA_W-1:0] w_core_data;

   // Round-robin pick: offsets are walked from the far end toward 0 so the
   // requesting port closest to ptr is the last, winning assignment.
   always_comb begin
      w_any_valid = 1'b0;
      w_pick_idx  = '0;
      w_scan      = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         w_scan = IDX_W'((int'(r_ptr) + i) % WIDTH);
         if (in_valid[w_scan]) begin
            w_any_valid = 1'b1;
            w_pick_idx  = w_scan;
         end
      end
   end

   // Explicit wrap keeps the pointer legal when WIDTH is not a power of two.
   assign w_gidx_inc  = (r_gidx == IDX_W'(WIDTH - 1)) ? '0 : r_gidx + IDX_W'(1);

   assign w_core_data = in_data[r_gidx * DATA_W +: DATA_W];
   assign w_core_last = in_last[r_gidx];
   assign w_core_xfer = w_core_valid & w_core_ready;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of the others, independent of block order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_gidx  <= '0;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_gidx  <= w_gidx_nxt;
         r_ptr   <= w_ptr_nxt;
      end
   end

   // NOTE: every signal driven here is given a default first, so no path
   // through the case leaves it unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_gidx_nxt  = r_gidx;
      w_ptr_nxt   = r_ptr;
      case (r_state)
         IDLE: begin
            if (w_any_valid) begin
               w_state_nxt = LOCKED;
               w_gidx_nxt  = w_pick_idx;
            end
         end
         LOCKED: begin
            // Only the packet's final transfer releases the grant and moves
            // the pointer; requests changing mid-packet are ignored.
            if (w_core_xfer && w_core_last) begin
               w_state_nxt = IDLE;
               w_ptr_nxt   = w_gidx_inc;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Output decode: IDLE is a bubble with nothing valid and nothing ready.
   always_comb begin
      w_core_valid = 1'b0;
      in_ready     = '0;
      if (r_state == LOCKED) begin
         w_core_valid     = in_valid[r_gidx];
         in_ready[r_gidx] = w_core_ready;
      end
   end

`ifdef ARMLEO_STREAM_ARBITER_OUTREG_EN
   localparam int PAYLOAD_W = DATA_W + 1 + IDX_W;

   logic [PAYLOAD_W-1:0] w_skid_data;

   armleo_stream_skid #(
      .PAYLOAD_W (PAYLOAD_W)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_s_valid (w_core_valid),
      .o_s_ready (w_core_ready),
      .i_s_data  ({w_core_data, w_core_last, r_gidx}),
      .o_m_valid (out_valid),
      .i_m_ready (out_ready),
      .o_m_data  (w_skid_data)
   );

   assign {out_data, out_last, out_idx} = w_skid_data;
`else
   assign w_core_ready = out_ready;
   assign out_valid    = w_core_valid;
   assign out_data     = w_core_data;
   assign out_last     = w_core_last;
   assign out_idx      = r_gidx;
`endif

endmodule

// File: tb/tb_armleo_stream_arbiter.sv
// ---------------------------------------------------------------------------
// tb_armleo_stream_arbiter
// Self-checking bench for armleo_stream_arbiter (WIDTH=4, DATA_W=32).
// Each port is fed from a queue of beats; the reference model tracks the
// packets still owed per port and predicts the next grant as the first port
// at or after the model pointer with a pending packet. Honors
// ARMLEO_STREAM_ARBITER_OUTREG_EN for the expected first-beat latency.
// ---------------------------------------------------------------------------
module tb_armleo_stream_arbiter;

   localparam int NP = 4;
   localparam int DW = 32;
`ifdef ARMLEO_STREAM_ARBITER_OUTREG_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 0;
`endif

   logic             clk;
   logic             rst_n;
   logic [NP-1:0]    in_valid;
   logic [NP-1:0]    in_ready;
   logic [NP*DW-1:0] in_data;
   logic [NP-1:0]    in_last;
   logic             out_valid;
   logic             out_ready;
   logic [DW-1:0]    out_data;
   logic             out_last;
   logic [1:0]       out_idx;

   armleo_stream_arbiter #(
      .WIDTH  (NP),
      .DATA_W (DW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_idx   (out_idx)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Source queues (what each upstream port still has to send) and the
   // model's copy (what the output still owes), bit DW = last flag.
   logic [DW:0]   src_q [NP][$];
   logic [DW:0]   exp_q [NP][$];
   int            src_gap [NP];
   int            pend [NP];
   int            gap_max;
   int            rdy_mode;
   int            m_ptr;
   int            m_cur;
   int            cyc;
   int            n_cmp;
   int            n_fail;
   int            log_idx [$];
   int            log_cyc [$];
   logic [DW-1:0] log_data [$];
   logic          prev_stall;
   logic [DW+2:0] prev_beat;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int pick();
      for (int i = 0; i < NP; i++) begin
         if (pend[(m_ptr + i) % NP] > 0) return (m_ptr + i) % NP;
      end
      return -1;
   endfunction

   function automatic int outstanding();
      int s = 0;
      for (int p = 0; p < NP; p++) s += exp_q[p].size();
      return s;
   endfunction

   task automatic drive_inputs();
      logic [DW:0] h;
      for (int p = 0; p < NP; p++) begin
         if (src_q[p].size() > 0 && src_gap[p] == 0) begin
            h                   = src_q[p][0];
            in_valid[p]         = 1'b1;
            in_data[p*DW +: DW] = h[DW-1:0];
            in_last[p]          = h[DW];
         end else begin
            in_valid[p]         = 1'b0;
            in_data[p*DW +: DW] = '0;
            in_last[p]          = 1'b0;
         end
      end
      case (rdy_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ($urandom_range(3, 0) != 0);
         default: out_ready = cyc[0];
      endcase
   endtask

   task automatic monitor();
      int          ep;
      logic [DW:0] eb;
      if (prev_stall) begin
         check("hold_valid", out_valid, 1'b1);
         check("hold_beat", {out_idx, out_last, out_data}, prev_beat);
      end
      if (out_valid && out_ready) begin
         log_idx.push_back(int'(out_idx));
         log_cyc.push_back(cyc);
         log_data.push_back(out_data);
         if (m_cur < 0) begin
            ep = pick();
            check("grant_idx", out_idx, ep);
            m_cur = ep;
         end else begin
            check("locked_idx", out_idx, m_cur);
         end
         if (m_cur < 0) begin
            check("spurious_beat", outstanding() > 0, 1'b1);
         end else begin
            eb = exp_q[m_cur].pop_front();
            check("beat", {out_last, out_data}, eb);
            if (eb[DW]) begin
               pend[m_cur]--;
               m_ptr = (m_cur + 1) % NP;
               m_cur = -1;
            end
         end
      end
      prev_stall = out_valid && !out_ready;
      prev_beat  = {out_idx, out_last, out_data};
   endtask

   task automatic step();
      logic [NP-1:0] acc;
      logic [DW:0]   tmp;
      @(negedge clk);
      acc = rst_n ? (in_valid & in_ready) : '0;
      if (rst_n) monitor();
      @(posedge clk);
      #1;
      cyc++;
      for (int p = 0; p < NP; p++) begin
         if (acc[p]) begin
            tmp = src_q[p].pop_front();
            if (!tmp[DW] && gap_max > 0) src_gap[p] = $urandom_range(gap_max, 0);
         end else if (src_gap[p] > 0) begin
            src_gap[p]--;
         end
      end
      drive_inputs();
   endtask

   task automatic flush();
      for (int p = 0; p < NP; p++) begin
         src_q[p].delete();
         exp_q[p].delete();
         src_gap[p] = 0;
         pend[p]    = 0;
      end
      m_ptr      = 0;
      m_cur      = -1;
      prev_stall = 1'b0;
   endtask

   task automatic clear_log();
      log_idx.delete();
      log_cyc.delete();
      log_data.delete();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      flush();
      drive_inputs();
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_in_ready", in_ready, 4'b0);
      rst_n = 1'b1;
   endtask

   task automatic load_packet(input int p, input int len, input logic [DW-1:0] base);
      logic [DW:0] beat;
      for (int b = 0; b < len; b++) begin
         beat = {(b == len - 1), base + DW'(b)};
         src_q[p].push_back(beat);
         exp_q[p].push_back(beat);
      end
      pend[p]++;
   endtask

   task automatic drain(input string tag, input int budget);
      for (int i = 0; i < budget && outstanding() > 0; i++) step();
      check({tag, "_drain"}, outstanding(), 0);
      repeat (3) step();
   endtask

   task automatic wait_beats(input string tag, input int n, input int budget);
      for (int i = 0; i < budget && log_idx.size() < n; i++) step();
      check(tag, log_idx.size(), n);
   endtask

   int c0;
   int total;

   initial begin
      n_cmp    = 0;
      n_fail   = 0;
      cyc      = 0;
      gap_max  = 0;
      rdy_mode = 0;
      rst_n    = 1'b0;
      in_valid = '0;
      in_data  = '0;
      in_last  = '0;
      out_ready = 1'b0;
      flush();
      do_reset();

      // Ports 0 and 2 with single-beat packets alternate, each grant after
      // a one-cycle idle bubble.
      clear_log();
      for (int k = 0; k < 3; k++) begin
         load_packet(0, 1, 32'h100 + k);
         load_packet(2, 1, 32'h200 + k);
      end
      drive_inputs();
      drain("alt02", 100);
      check("alt02_count", log_idx.size(), 6);
      for (int k = 0; k < log_idx.size(); k++) begin
         check("alt02_idx", log_idx[k], (k % 2 == 0) ? 0 : 2);
         if (k > 0) check("alt02_gap", log_cyc[k] - log_cyc[k-1], 2);
      end

      // Port 1 three-beat packet; port 3 requests mid-packet and must wait.
      do_reset();
      clear_log();
      load_packet(1, 3, 32'hA1);
      drive_inputs();
      wait_beats("p1_first", 1, 50);
      load_packet(3, 2, 32'hB1);
      drive_inputs();
      drain("p1p3", 100);
      check("p1p3_count", log_idx.size(), 5);
      for (int k = 0; k < log_idx.size(); k++) begin
         check("p1p3_idx", log_idx[k], (k < 3) ? 1 : 3);
         check("p1p3_data", log_data[k], (k < 3) ? (32'hA1 + k) : (32'hB1 + k - 3));
      end

      // All four ports busy: grants rotate 0,1,2,3 and wrap back to 0.
      do_reset();
      clear_log();
      for (int k = 0; k < 2; k++) begin
         for (int p = 0; p < NP; p++) load_packet(p, 1, 32'h300 + 16 * p + k);
      end
      drive_inputs();
      drain("rr4", 100);
      check("rr4_count", log_idx.size(), 8);
      for (int k = 0; k < log_idx.size(); k++) check("rr4_idx", log_idx[k], k % NP);

      // Toggling out_ready during a 4-beat packet: stalled beats must hold.
      do_reset();
      clear_log();
      rdy_mode = 2;
      load_packet(2, 4, 32'hC0);
      drive_inputs();
      drain("toggle", 100);
      rdy_mode = 0;
      check("toggle_count", log_idx.size(), 4);
      for (int k = 0; k < log_idx.size(); k++) begin
         check("toggle_idx", log_idx[k], 2);
         check("toggle_data", log_data[k], 32'hC0 + k);
      end

      // Reset in the middle of a port-2 packet while ptr sits at 2.
      do_reset();
      clear_log();
      load_packet(1, 1, 32'h11);
      drive_inputs();
      drain("pre_rst", 50);
      clear_log();
      load_packet(2, 4, 32'h20);
      drive_inputs();
      wait_beats("mid_pkt", 2, 50);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_in_ready", in_ready, 4'b0);
      flush();
      rst_n = 1'b1;
      clear_log();
      load_packet(1, 1, 32'h31);
      load_packet(2, 1, 32'h32);
      drive_inputs();
      drain("post_rst", 100);
      check("post_rst_count", log_idx.size(), 2);
      if (log_idx.size() > 0) check("post_rst_first", log_idx[0], 1);
      if (log_idx.size() > 1) check("post_rst_second", log_idx[1], 2);

      // Continuous 8-beat packet: first-beat latency and back-to-back beats.
      do_reset();
      clear_log();
      load_packet(0, 8, 32'h80);
      drive_inputs();
      c0 = cyc;
      drain("burst8", 100);
      check("burst8_count", log_idx.size(), 8);
      if (log_idx.size() > 0) check("burst8_latency", log_cyc[0] - c0, 1 + LAT);
      for (int k = 1; k < log_idx.size(); k++) check("burst8_b2b", log_cyc[k] - log_cyc[k-1], 1);

      // Randomized rounds: random packets, intra-packet bubbles, random ready.
      for (int r = 0; r < 4; r++) begin
         do_reset();
         clear_log();
         rdy_mode = 1;
         gap_max  = 2;
         for (int p = 0; p < NP; p++) begin
            for (int j = 0; j < int'($urandom_range(3, 0)); j++) begin
               load_packet(p, int'($urandom_range(5, 1)), $urandom);
            end
         end
         total = outstanding();
         drive_inputs();
         drain("rand", 3000);
         check("rand_count", log_idx.size(), total);
      end
      rdy_mode = 0;
      gap_max  = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/armleo_stream_arbiter.md
ARMLEO_STREAM_ARBITER -- requirements
Module: armleo_stream_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, number of input ports (2..16).
REQ-002 SHALL have parameter DATA_W, default 32, payload bits per beat.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  WIDTH  per-port beat valid.
REQ-006 SHALL have port in_ready  output  WIDTH  per-port beat accept.
REQ-007 SHALL have port in_data  input  WIDTH*DATA_W  flat payload; port i at bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port in_last  input  WIDTH  per-port last beat of packet.
REQ-009 SHALL have port out_valid  output  1  merged beat valid.
REQ-010 SHALL have port out_ready  input  1  downstream accept.
REQ-011 SHALL have port out_data  output  DATA_W  merged payload.
REQ-012 SHALL have port out_last  output  1  merged last flag.
REQ-013 SHALL have port out_idx  output  $clog2(WIDTH)  source port of current beat.

Function
REQ-014 SHALL implement FSM states IDLE and LOCKED, with registered grant index gidx and priority pointer ptr.
REQ-015 In IDLE with any in_valid set, SHALL pick the first set port scanning ptr, ptr+1, ... modulo WIDTH, load gidx, and go to LOCKED next cycle.
REQ-016 In IDLE, in_ready SHALL be all-zero and out_valid SHALL be 0 (one-cycle arbitration bubble per packet).
REQ-017 In LOCKED, out_valid/out_data/out_last SHALL equal port gidx inputs, in_ready[gidx] SHALL equal out_ready, and all other in_ready SHALL be 0.
REQ-018 A beat SHALL transfer when out_valid and out_ready are both 1; only transfers advance state.
REQ-019 On a transfer with out_last=1, SHALL set ptr to (gidx+1) mod WIDTH and return to IDLE.
REQ-020 ptr SHALL change only at packet end; requests arriving or withdrawn mid-packet SHALL NOT alter gidx or ptr.
REQ-021 In LOCKED with in_valid[gidx]=0 (gap), SHALL hold LOCKED with out_valid=0.
REQ-022 Wrap-around: gidx=WIDTH-1 at packet end SHALL yield ptr=0.
REQ-023 out_idx SHALL equal gidx whenever out_valid=1.
REQ-024 Upstream ports SHALL hold valid/data stable until accepted (AXI-stream rule); the block SHALL NOT drop or duplicate beats.

Reset
REQ-025 With rst_n=0 at a clock edge: state=IDLE, ptr=0, gidx=0, out_valid=0, in_ready=0, skid buffer empty.
REQ-026 Reset mid-packet SHALL abandon the packet; the first post-reset arbitration SHALL start from ptr=0.

Configuration
REQ-027 Macro ARMLEO_STREAM_ARBITER_OUTREG_EN defined: outputs SHALL pass through a 2-entry skid buffer, adding exactly one cycle latency, sustaining one beat/cycle, and leaving no combinational path from out_ready to in_ready.
REQ-028 Macro undefined: outputs SHALL be combinational from the selected port, with zero added latency.

Structure
REQ-029 Shared package armleo_stream_pkg SHALL hold the FSM state enum (IDLE, LOCKED) and the skid-buffer depth constant (2).
REQ-030 SHALL instantiate one sub-module, armleo_stream_skid (valid/ready/data+last+idx skid buffer), only under ARMLEO_STREAM_ARBITER_OUTREG_EN.

Verification
REQ-031 Ports 0 and 2 hold 1-beat packets, out_ready=1, WIDTH=4 -> grants 0,2,0,2...; every grant follows a 1-cycle IDLE gap.
REQ-032 Port 1 sends 3-beat packet (D=0xA1,0xA2,0xA3), port 3 asserts valid at beat 2 -> all three port-1 beats appear contiguously before any port-3 beat; then ptr=2 and port 3 is granted.
REQ-033 All 4 ports continuously valid with 1-beat packets -> out_idx sequence 0,1,2,3,0; wrap from 3 to 0 verified.
REQ-034 out_ready toggles 1,0,1,0 during a 4-beat packet -> exactly 4 beats, in order; data stable while out_valid=1 and out_ready=0.
REQ-035 rst_n=0 asserted for one cycle after beat 2 of a port-2 packet -> next cycle out_valid=0, in_ready=0; with ports 1 and 2 valid afterward, port 1 is granted (ptr=0).
REQ-036 With OUTREG_EN, continuous 8-beat packet, out_ready=1 -> first out_valid one cycle later than without the macro, then 8 consecutive beats.
